// File: rtl/bmem_pkg.sv
// Shared constants, FSM state types and read-queue entry layout for the
// burst memory responder.
package bmem_pkg;

    localparam int BMEM_BEATS  = 4;
    localparam int BMEM_LINE_W = 256;
    localparam int BMEM_BEAT_W = 64;

    typedef enum logic [2:0] {
        R_IDLE, R_WAIT, R_BEAT0, R_BEAT1, R_BEAT2, R_BEAT3
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE, W_B1, W_B2, W_B3
    } wr_state_t;

    // Full line address (bmem_addr[31:5]) plus the acceptance cycle stamp.
    typedef struct packed {
        logic [26:0] line;
        logic [7:0]  stamp;
    } rq_entry_t;

    localparam int RQ_ENTRY_W = $bits(rq_entry_t);

endpackage

// File: rtl/bmem_req_fifo.sv
// Read-request queue; also exposes the entry behind the head so the return
// FSM can decide on back-to-back bursts. Push while full is taken if a pop
// happens in the same cycle.
module bmem_req_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [WIDTH-1:0]         dout_nxt,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign count    = cnt;
    assign dout     = mem[rd_ptr];
    assign dout_nxt = mem[rd_ptr + AW'(1)];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Line memory with 4-beat write bursts and queued, latency-controlled 4-beat
// read returns. Define BMEM_RESP_STALL_EN to throttle bmem_ready with an LFSR.
module burst_mem_responder
    import bmem_pkg::*;
#(
    parameter int MEM_LINES = 256,
    parameter int READ_LAT  = 4,
    parameter int RQ_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic        proto_err
);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(RQ_DEPTH) + 1;

    rd_state_t rd_state;
    wr_state_t wr_state;

    logic [BMEM_LINE_W-1:0]             mem [MEM_LINES];
    logic [BMEM_LINE_W-BMEM_BEAT_W-1:0] wbuf;
    logic [IDX_W-1:0]                   w_idx;
    logic [BMEM_LINE_W-1:0]             rline;
    logic [7:0]                         stamp_cnt;
    logic                               rvalid_q, err_q;
    logic [63:0]                        rdata_q;
    logic [31:0]                        raddr_q;

    logic      w_open, ready_base, ready_int, wr_acc, rd_acc;
    logic      q_full, q_empty, q_pop;
    logic [CNT_W-1:0] q_count;
    rq_entry_t push_e, q_dout, q_dout_nxt, nh;
    logic      nh_vld, nh_mature;
    logic [7:0] nh_age;
    logic      unused_ok;

    assign unused_ok  = ^bmem_addr[4:0];
    assign w_open     = (wr_state != W_IDLE);
    assign q_pop      = (rd_state == R_BEAT3);
    // A pop in this cycle frees a slot, so a read may be taken even when full.
    assign ready_base = w_open | ~q_full | q_pop;

`ifdef BMEM_RESP_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    assign ready_int = ready_base & lfsr[0];
`else
    assign ready_int = ready_base;
`endif

    assign bmem_ready  = rst & ready_int;
    assign wr_acc      = bmem_write & bmem_ready;
    assign rd_acc      = bmem_read & bmem_ready & ~w_open & ~bmem_write;
    assign push_e      = '{line: bmem_addr[31:5], stamp: stamp_cnt};

    assign bmem_rvalid = rst & rvalid_q;
    assign bmem_rdata  = bmem_rvalid ? rdata_q : '0;
    assign bmem_raddr  = bmem_rvalid ? raddr_q : '0;
    assign proto_err   = rst & err_q;

    bmem_req_fifo #(.WIDTH(RQ_ENTRY_W), .DEPTH(RQ_DEPTH)) u_rq (
        .clk(clk), .rst(rst), .push(rd_acc), .pop(q_pop), .din(push_e),
        .dout(q_dout), .dout_nxt(q_dout_nxt), .full(q_full), .empty(q_empty),
        .count(q_count)
    );

    // Entry that will sit at the queue head next cycle, and whether it has
    // aged enough by then for its burst to start.
    always_comb begin
        nh     = q_dout;
        nh_vld = 1'b0;
        if (q_pop) begin
            if (q_count >= CNT_W'(2)) begin
                nh = q_dout_nxt; nh_vld = 1'b1;
            end else if (rd_acc) begin
                nh = push_e; nh_vld = 1'b1;
            end
        end else if (!q_empty) begin
            nh = q_dout; nh_vld = 1'b1;
        end else if (rd_acc) begin
            nh = push_e; nh_vld = 1'b1;
        end
        nh_age    = stamp_cnt + 8'd1 - nh.stamp;
        nh_mature = (nh_age >= 8'(READ_LAT));
    end

    always_ff @(posedge clk) begin
        if (!rst) stamp_cnt <= '0;
        else      stamp_cnt <= stamp_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state <= R_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            raddr_q  <= '0;
        end else begin
            case (rd_state)
                R_IDLE, R_WAIT, R_BEAT3: begin
                    if (nh_vld && nh_mature) begin
                        rd_state <= R_BEAT0;
                        rvalid_q <= 1'b1;
                        rline    <= mem[nh.line[IDX_W-1:0]];
                        rdata_q  <= mem[nh.line[IDX_W-1:0]][63:0];
                        raddr_q  <= {nh.line, 5'b0};
                    end else begin
                        rd_state <= nh_vld ? R_WAIT : R_IDLE;
                        rvalid_q <= 1'b0;
                        rdata_q  <= '0;
                        raddr_q  <= '0;
                    end
                end
                R_BEAT0: begin rd_state <= R_BEAT1; rdata_q <= rline[127:64];  end
                R_BEAT1: begin rd_state <= R_BEAT2; rdata_q <= rline[191:128]; end
                R_BEAT2: begin rd_state <= R_BEAT3; rdata_q <= rline[255:192]; end
                default: begin
                    rd_state <= R_IDLE;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_state <= W_IDLE;
            err_q    <= 1'b0;
        end else begin
            if (bmem_read && (w_open || bmem_write)) err_q <= 1'b1;
            if (wr_acc) begin
                case (wr_state)
                    W_IDLE:  wr_state <= W_B1;
                    W_B1:    wr_state <= W_B2;
                    W_B2:    wr_state <= W_B3;
                    default: wr_state <= W_IDLE;
                endcase
            end
        end
    end

    // Beats are staged in wbuf; only the last beat writes the array, so a
    // burst cut short by reset never reaches memory.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            case (wr_state)
                W_IDLE: begin
                    w_idx       <= bmem_addr[5+IDX_W-1:5];
                    wbuf[63:0]  <= bmem_wdata;
                end
                W_B1:    wbuf[127:64]  <= bmem_wdata;
                W_B2:    wbuf[191:128] <= bmem_wdata;
                default: mem[w_idx]    <= {bmem_wdata, wbuf};
            endcase
        end
    end

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter MEM_LINES, default 256: number of 256-bit lines; must be a power of 2.
REQ-002 SHALL have parameter READ_LAT, default 4, legal 1..15: minimum cycles from read acceptance to first read beat.
REQ-003 SHALL have parameter RQ_DEPTH, default 4, legal power of 2 >= 2: read-request queue depth.
REQ-004 SHALL have ports, clock and reset first:
 clk  in  1  clock; all logic on its rising edge.
 rst  in  1  reset; synchronous, active-low.
 bmem_addr  in  32  line address; sampled on beat 0 of a write and on a read.
 bmem_read  in  1  read request.
 bmem_write  in  1  write beat request.
 bmem_wdata  in  64  write beat data.
 bmem_ready  out  1  a request or beat is accepted when it is high.
 bmem_raddr  out  32  line address of the returning burst.
 bmem_rdata  out  64  read beat data.
 bmem_rvalid  out  1  read beat valid.
 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-005 SHALL accept a read in any cycle with bmem_read & bmem_ready & no write burst open, and push {line index} into the read queue.
REQ-006 SHALL compute line index = bmem_addr[5+log2(MEM_LINES)-1:5]; bits [4:0] ignored; higher bits ignored, so addresses wrap.
REQ-007 SHALL take a write as 4 accepted beats (bmem_write & bmem_ready), beat k carrying bytes [64k+63:64k]; address is sampled on beat 0 only.
REQ-008 SHALL commit the full line to memory at the edge that accepts beat 3; a read accepted in the following cycle SHALL return the new data.
REQ-009 SHALL return each read as 4 beats on consecutive cycles, beat 0 = bytes [63:0]; bmem_raddr = {line addr, 5'b0} on all 4 beats.
REQ-010 SHALL, for a read accepted at cycle T, emit beat 0 at cycle max(T+READ_LAT, L+1), where L is the last beat cycle of the previous burst.
REQ-011 SHALL return reads strictly in acceptance order.
REQ-012 SHALL drive bmem_rdata = 0 and bmem_raddr = 0 when bmem_rvalid is low.
REQ-013 SHALL drive bmem_ready = ~queue_full, except that it stays 1 while a write burst is open.
REQ-014 SHALL run a return FSM with states R_IDLE, R_WAIT, R_BEAT0..R_BEAT3:
 R_IDLE -> R_WAIT when the queue is non-empty.
 R_WAIT -> R_BEAT0 when the head entry's age reaches READ_LAT.
 R_BEAT3 -> R_BEAT0 when the next head has matured; -> R_WAIT when it has not; -> R_IDLE when the queue is empty.
 The queue pops on R_BEAT3.
REQ-015 SHALL track entry age with a free-running 8-bit cycle stamp stored per entry, compared modulo 256.
REQ-016 SHALL run a write FSM with states W_IDLE, W_B1, W_B2, W_B3; it advances only on accepted beats.
REQ-017 SHALL handle bmem_read and bmem_write both high in W_IDLE by taking the write, ignoring the read and setting proto_err.
REQ-018 SHALL ignore bmem_read while the write FSM is not in W_IDLE and set proto_err.
REQ-019 SHALL allow a read to be accepted in the same cycle a burst is returning, and in the same cycle the queue pops while full.
REQ-020 SHALL never write memory from a partial burst; a burst abandoned by reset is discarded.

Reset
REQ-021 SHALL, while rst = 0, hold bmem_ready = 0, bmem_rvalid = 0, bmem_rdata = 0, bmem_raddr = 0 and proto_err = 0; both FSMs return to idle and the queue and stamp counter clear.
REQ-022 SHALL keep memory contents across reset and treat them as undefined after power-up; an in-flight read burst is truncated immediately by reset.
REQ-023 SHALL raise bmem_ready in the first cycle after rst returns high.

Configuration
REQ-024 With BMEM_RESP_STALL_EN defined, SHALL AND bmem_ready with bit 0 of a 16-bit LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset, stepping every cycle); this applies mid-write-burst too, and beats are taken only when ready is high.
REQ-025 Without BMEM_RESP_STALL_EN, SHALL contain no LFSR, and bmem_ready SHALL follow REQ-013 exactly.

Structure
REQ-026 SHALL take BMEM_BEATS = 4, BMEM_LINE_W = 256, BMEM_BEAT_W = 64 and the rd_state_t/wr_state_t enums from shared package bmem_pkg.
REQ-027 SHALL place the read queue in sub-module bmem_req_fifo (parameterised width/depth, push/pop/full/empty, simultaneous push+pop when full legal).

Verification
REQ-028 Write line 0x0000_0040 with beats 1,2,3,4, then read 0x40 at cycle T -> rvalid at T+4..T+7, rdata 1,2,3,4, raddr 0x40.
REQ-029 Reads of 0x00, 0x20, 0x40, 0x60 accepted on 4 consecutive cycles from T -> ready low at T+4; 16 contiguous beats starting T+4, in order.
REQ-030 Read address 0x0000_2020 with MEM_LINES = 256 -> returns the data of line 0x020 (wrap); raddr = 0x0000_2020.
REQ-031 Read and write asserted together in W_IDLE -> write completes normally, no read burst, proto_err = 1 until reset.
REQ-032 rst low after write beat 2 of line 0x80 (old data A), then read 0x80 -> returns A unchanged.
REQ-033 With BMEM_RESP_STALL_EN, 100 random writes then read-back -> all data match, each beat taken only when ready is high.
